// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: register-file geometry, write requests and
// write-port source tags used by the writeback arbiter.
package mips_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MDU
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding MDU writeback requests until they win the
// register-file write port. DEPTH must be a power of two, at least 2.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  wb_req_t     push_req,
  input  logic        pop,
  output wb_req_t     head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_req;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: shares the single port between the WB
// stage and buffered MDU results, with starvation relief and a pending
// scoreboard. Define RF_WB_BYPASS_EN to let MDU results skip an empty FIFO.
module rf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_waddr,
  input  logic [DATA_W-1:0] mdu_wdata,
  input  logic              mdu_issue_valid,
  input  logic [REG_AW-1:0] mdu_issue_addr,
  input  logic [REG_AW-1:0] chk_addr_1,
  input  logic [REG_AW-1:0] chk_addr_2,
  output logic              chk_busy_1,
  output logic              chk_busy_2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = 1;
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);

  wb_req_t       pipe_req, mdu_req, fifo_head, grant_req;
  wb_src_e       grant_src;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, bypass;
  logic [CW-1:0] fifo_count;

  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       pending_q, pending_d;
  logic              rf_we_q, rf_we_d, rf_mdu_q, rf_mdu_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  assign pipe_req = '{we: 1'b1, waddr: pipe_waddr, wdata: pipe_wdata};
  assign mdu_req  = '{we: 1'b1, waddr: mdu_waddr,  wdata: mdu_wdata};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (mdu_req),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign pipe_stall = (starve_q == STARVE_MAX);
  assign mdu_ready  = (fifo_count < DEPTH_CNT);
  assign fifo_push  = mdu_valid && !fifo_full && !bypass;

  // A stalled pipe request is re-presented next cycle, so it never wins here.
  always_comb begin
    grant_src = SRC_NONE;
    grant_req = '0;
    fifo_pop  = 1'b0;
    bypass    = 1'b0;
    if (pipe_stall && !fifo_empty) begin
      grant_src = SRC_MDU;
      grant_req = fifo_head;
      fifo_pop  = 1'b1;
    end else if (pipe_we && !pipe_stall) begin
      grant_src = SRC_PIPE;
      grant_req = pipe_req;
    end else if (!fifo_empty) begin
      grant_src = SRC_MDU;
      grant_req = fifo_head;
      fifo_pop  = 1'b1;
    end
`ifdef RF_WB_BYPASS_EN
    else if (mdu_valid) begin
      grant_src = SRC_MDU;
      grant_req = mdu_req;
      bypass    = 1'b1;
    end
`else
`endif
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty)      starve_d = '0;
    else if (pipe_we && !pipe_stall) starve_d = starve_q + STARVE_ONE;
  end

  // r0 requests still take the grant but never reach the register file.
  always_comb begin
    rf_we_d    = (grant_src != SRC_NONE) && grant_req.we && (grant_req.waddr != '0);
    rf_mdu_d   = rf_we_d && (grant_src == SRC_MDU);
    rf_waddr_d = grant_req.waddr;
    rf_wdata_d = grant_req.wdata;
  end

  // Set after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    pending_d = pending_q;
    if (rf_mdu_q) pending_d[rf_waddr_q] = 1'b0;
    if (mdu_issue_valid && (mdu_issue_addr != '0)) pending_d[mdu_issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_mdu_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_mdu_q   <= rf_mdu_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign chk_busy_1 = pending_q[chk_addr_1];
  assign chk_busy_2 = pending_q[chk_addr_2];
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: hand-computed expectations for pipe
// writes, MDU latency, starvation relief, FIFO full, r0 and async reset.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        mdu_issue_valid;
  logic [4:0]  mdu_issue_addr;
  logic [4:0]  chk_addr_1, chk_addr_2;
  logic        chk_busy_1, chk_busy_2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int vectors = 0;
  int miscompares = 0;

`ifdef RF_WB_BYPASS_EN
  localparam int MDU_LAT = 1;
`else
  localparam int MDU_LAT = 2;
`endif

  rf_wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_we         (pipe_we),
    .pipe_waddr      (pipe_waddr),
    .pipe_wdata      (pipe_wdata),
    .pipe_stall      (pipe_stall),
    .mdu_valid       (mdu_valid),
    .mdu_ready       (mdu_ready),
    .mdu_waddr       (mdu_waddr),
    .mdu_wdata       (mdu_wdata),
    .mdu_issue_valid (mdu_issue_valid),
    .mdu_issue_addr  (mdu_issue_addr),
    .chk_addr_1      (chk_addr_1),
    .chk_addr_2      (chk_addr_2),
    .chk_busy_1      (chk_busy_1),
    .chk_busy_2      (chk_busy_2),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
    if (we) begin
      chk({tag, ".addr"}, {27'd0, rf_waddr}, {27'd0, a});
      chk({tag, ".data"}, rf_wdata, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    mdu_valid = 0; mdu_waddr = 0; mdu_wdata = 0;
    mdu_issue_valid = 0; mdu_issue_addr = 0;
    chk_addr_1 = 0; chk_addr_2 = 0;
    tick(); tick();

    // Reset state
    chk("rst.rf_we", {31'd0, rf_we}, 0);
    chk("rst.rf_waddr", {27'd0, rf_waddr}, 0);
    chk("rst.rf_wdata", rf_wdata, 0);
    chk("rst.stall", {31'd0, pipe_stall}, 0);
    chk("rst.ready", {31'd0, mdu_ready}, 1);
    rst = 1'b0;

    // Pipe write, one-cycle latency
    pipe_we = 1; pipe_waddr = 5; pipe_wdata = 32'h1234;
    tick();
    chk_rf("pipe1", 1, 5, 32'h1234);
    pipe_we = 0;
    tick();
    chk_rf("pipe1.idle", 0, 0, 0);

    // MDU op to r8: scoreboard and commit latency
    mdu_issue_valid = 1; mdu_issue_addr = 8;
    tick();
    mdu_issue_valid = 0;
    chk_addr_1 = 8; chk_addr_2 = 9;
    #1;
    chk("r8.busy.issue", {31'd0, chk_busy_1}, 1);
    chk("r9.busy", {31'd0, chk_busy_2}, 0);
    tick(); tick();
    mdu_valid = 1; mdu_waddr = 8; mdu_wdata = 32'hDEAD;
    tick();
    mdu_valid = 0;
    for (int i = 1; i < MDU_LAT; i++) begin
      chk("r8.wait.we", {31'd0, rf_we}, 0);
      chk("r8.wait.busy", {31'd0, chk_busy_1}, 1);
      tick();
    end
    chk_rf("r8.commit", 1, 8, 32'hDEAD);
    chk("r8.busy.commit", {31'd0, chk_busy_1}, 1);
    tick();
    chk("r8.busy.after", {31'd0, chk_busy_1}, 0);
    chk_rf("r8.after", 0, 0, 0);

    // Starvation: pipe busy, one MDU result queued
    pipe_we = 1; pipe_waddr = 10; pipe_wdata = 32'hA0;
    mdu_valid = 1; mdu_waddr = 12; mdu_wdata = 32'hC0;
    tick();
    mdu_valid = 0;
    chk_rf("stv.e0", 1, 10, 32'hA0);
    chk("stv.e0.stall", {31'd0, pipe_stall}, 0);
    pipe_waddr = 11; pipe_wdata = 32'hA1;
    tick();
    chk_rf("stv.e1", 1, 11, 32'hA1);
    chk("stv.e1.stall", {31'd0, pipe_stall}, 0);
    pipe_waddr = 13; pipe_wdata = 32'hA3;
    tick();
    chk_rf("stv.e2", 1, 13, 32'hA3);
    chk("stv.e2.stall", {31'd0, pipe_stall}, 0);
    pipe_waddr = 14; pipe_wdata = 32'hA4;
    tick();
    chk_rf("stv.e3", 1, 14, 32'hA4);
    chk("stv.e3.stall", {31'd0, pipe_stall}, 1);
    pipe_waddr = 15; pipe_wdata = 32'hA5;
    tick();
    chk_rf("stv.e4", 1, 12, 32'hC0);
    chk("stv.e4.stall", {31'd0, pipe_stall}, 0);
    tick();
    chk_rf("stv.e5", 1, 15, 32'hA5);
    pipe_we = 0;
    tick();
    chk_rf("stv.idle", 0, 0, 0);

    // FIFO fill with pipe busy, 5th result refused, drain in order
    pipe_we = 1; pipe_waddr = 20; pipe_wdata = 32'h20;
    mdu_valid = 1; mdu_waddr = 1; mdu_wdata = 32'h11;
    tick();
    chk_rf("full.e0", 1, 20, 32'h20);
    chk("full.e0.ready", {31'd0, mdu_ready}, 1);
    mdu_waddr = 2; mdu_wdata = 32'h22;
    tick();
    mdu_waddr = 3; mdu_wdata = 32'h33;
    tick();
    mdu_waddr = 4; mdu_wdata = 32'h44;
    tick();
    chk("full.ready", {31'd0, mdu_ready}, 0);
    chk("full.stall", {31'd0, pipe_stall}, 1);
    mdu_waddr = 5; mdu_wdata = 32'h55;
    tick();
    chk_rf("drain.1", 1, 1, 32'h11);
    mdu_valid = 0; pipe_we = 0;
    chk("drain.ready", {31'd0, mdu_ready}, 1);
    chk("drain.stall", {31'd0, pipe_stall}, 0);
    tick();
    chk_rf("drain.2", 1, 2, 32'h22);
    tick();
    chk_rf("drain.3", 1, 3, 32'h33);
    tick();
    chk_rf("drain.4", 1, 4, 32'h44);
    tick();
    chk_rf("drain.empty", 0, 0, 0);

    // r0 result: pops but never writes or marks pending
    mdu_issue_valid = 1; mdu_issue_addr = 0;
    mdu_valid = 1; mdu_waddr = 0; mdu_wdata = 32'hFFFF;
    tick();
    mdu_issue_valid = 0; mdu_valid = 0;
    chk_addr_1 = 0;
    #1;
    chk("r0.busy", {31'd0, chk_busy_1}, 0);
    for (int i = 1; i < MDU_LAT; i++) tick();
    chk_rf("r0.commit", 0, 0, 0);
    mdu_valid = 1; mdu_waddr = 9; mdu_wdata = 32'h99;
    tick();
    mdu_valid = 0;
    for (int i = 1; i < MDU_LAT; i++) tick();
    chk_rf("r0.next", 1, 9, 32'h99);

    // Async reset mid-drain: two queued, pending[3] set
    pipe_we = 1; pipe_waddr = 21; pipe_wdata = 32'h21;
    mdu_valid = 1; mdu_waddr = 3; mdu_wdata = 32'h33;
    mdu_issue_valid = 1; mdu_issue_addr = 3;
    tick();
    mdu_issue_valid = 0;
    mdu_waddr = 6; mdu_wdata = 32'h66;
    tick();
    pipe_we = 0; mdu_valid = 0;
    chk_addr_1 = 3;
    #1;
    chk_rf("mid.pipe", 1, 21, 32'h21);
    chk("mid.busy3", {31'd0, chk_busy_1}, 1);
    rst = 1'b1;
    #1;
    chk("mid.rst.we", {31'd0, rf_we}, 0);
    chk("mid.rst.waddr", {27'd0, rf_waddr}, 0);
    chk("mid.rst.wdata", rf_wdata, 0);
    chk("mid.rst.stall", {31'd0, pipe_stall}, 0);
    chk("mid.rst.ready", {31'd0, mdu_ready}, 1);
    chk("mid.rst.busy3", {31'd0, chk_busy_1}, 0);
    #1;
    rst = 1'b0;
    tick();
    chk_rf("post.rst.1", 0, 0, 0);
    tick();
    chk_rf("post.rst.2", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
